// File: rtl/phase_tracker_pkg.sv
// phase_tracker_pkg: shared FSM states and helpers for multi_bin_phase_tracker
package phase_tracker_pkg;

   typedef enum logic [1:0] {CAPTURE, SEND, WAIT, UPDATE} state_t;

   function automatic int slot_cnt_width(input int num_bins);
      return $clog2(num_bins + 1);
   endfunction

   // Phase words are fractions of a turn, so plain modular subtraction is the wrapped delta.
   function automatic logic [31:0] phase_wrap_sub(input logic [31:0] a, input logic [31:0] b);
      return a - b;
   endfunction

endpackage

// File: rtl/multi_bin_phase_tracker.sv
// multi_bin_phase_tracker: per-frame phase advance of NUM_BINS selected FFT bins via an external CORDIC
module multi_bin_phase_tracker
   import phase_tracker_pkg::*;
#(
   parameter int DATA_WIDTH  = 24,
   parameter int ADDR_WIDTH  = 11,
   parameter int PHASE_WIDTH = 24,
   parameter int NUM_BINS    = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [2*DATA_WIDTH-1:0]         fft_tdata,
   input  logic                            fft_tvalid,
   output logic                            fft_tready,
   input  logic                            fft_tlast,
   input  logic [ADDR_WIDTH-1:0]           fft_tuser,
   input  logic [NUM_BINS*ADDR_WIDTH-1:0]  bin_sel,
   output logic [2*DATA_WIDTH-1:0]         cordic_in_tdata,
   output logic                            cordic_in_tvalid,
   input  logic                            cordic_in_tready,
   input  logic [PHASE_WIDTH-1:0]          cordic_out_tdata,
   input  logic                            cordic_out_tvalid,
   output logic [NUM_BINS*PHASE_WIDTH-1:0] phase_cur,
   output logic [NUM_BINS*PHASE_WIDTH-1:0] dphase,
   output logic [NUM_BINS-1:0]             dphase_stale,
   output logic                            dphase_valid
);

   localparam int CW = slot_cnt_width(NUM_BINS);

   state_t state, state_next;
   logic frame_start;
   logic [NUM_BINS-1:0][ADDR_WIDTH-1:0] bin_lat, bin_prev;
   logic [NUM_BINS-1:0][2*DATA_WIDTH-1:0] cap;
   logic [NUM_BINS-1:0][PHASE_WIDTH-1:0] cur, prev;
   logic [NUM_BINS-1:0] seen, hist_valid, match;
   logic [CW-1:0] send_idx, res_cnt;
   logic beat_acc, req_hs, res_acc, results_done;

   assign fft_tready       = state == CAPTURE;
   assign cordic_in_tvalid = state == SEND;
   assign dphase_valid     = state == UPDATE;
   assign beat_acc         = fft_tvalid && fft_tready;
   assign req_hs           = cordic_in_tvalid && cordic_in_tready;
   assign results_done     = res_cnt == CW'(NUM_BINS);
   assign res_acc          = cordic_out_tvalid && (state == SEND || state == WAIT) && !results_done;

   for (genvar g = 0; g < NUM_BINS; g++) begin : g_match
      assign match[g] = seen[g] && hist_valid[g] && bin_lat[g] == bin_prev[g];
   end

   // Unseen slots still issue a request so result n always maps to slot n.
   always_comb begin
      cordic_in_tdata = '0;
      for (int i = 0; i < NUM_BINS; i++)
         if (state == SEND && send_idx == CW'(i) && seen[i]) cordic_in_tdata = cap[i];
   end

   always_comb begin
      state_next = state;
      case (state)
         CAPTURE: if (beat_acc && fft_tlast) state_next = SEND;
         SEND:    if (req_hs && send_idx == CW'(NUM_BINS - 1)) state_next = WAIT;
         WAIT:    if (results_done) state_next = UPDATE;
         default: state_next = CAPTURE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= CAPTURE;
      else state <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_start  <= 1'b1;
         seen         <= '0;
         hist_valid   <= '0;
         send_idx     <= '0;
         res_cnt      <= '0;
         phase_cur    <= '0;
         dphase       <= '0;
         dphase_stale <= '1;
      end else begin
         if (beat_acc) frame_start <= fft_tlast;
         send_idx <= state == CAPTURE ? '0 : send_idx + CW'(req_hs);
         res_cnt  <= state == CAPTURE ? '0 : res_cnt + CW'(res_acc);
         if (state == UPDATE) seen <= '0;
         for (int i = 0; i < NUM_BINS; i++) begin
            if (beat_acc && frame_start) bin_lat[i] <= bin_sel[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (beat_acc && fft_tuser == (frame_start ? bin_sel[i*ADDR_WIDTH +: ADDR_WIDTH] : bin_lat[i])) begin
               cap[i]  <= fft_tdata;
               seen[i] <= 1'b1;
            end
            if (res_acc && res_cnt == CW'(i)) cur[i] <= cordic_out_tdata;
            if (state == WAIT && results_done) begin
               dphase[i*PHASE_WIDTH +: PHASE_WIDTH] <= match[i] ? PHASE_WIDTH'(phase_wrap_sub(32'(cur[i]), 32'(prev[i]))) : '0;
               dphase_stale[i] <= !match[i];
               hist_valid[i]   <= seen[i];
               if (seen[i]) begin
                  prev[i]     <= cur[i];
                  bin_prev[i] <= bin_lat[i];
                  phase_cur[i*PHASE_WIDTH +: PHASE_WIDTH] <= cur[i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_bin_phase_tracker.sv
// tb_multi_bin_phase_tracker: directed frames with a scripted 3-cycle CORDIC and a scoreboard on dphase_valid
module tb_multi_bin_phase_tracker;

   localparam int DW = 24, AW = 4, PW = 24, NB = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [2*DW-1:0] fft_tdata;
   logic fft_tvalid, fft_tready, fft_tlast;
   logic [AW-1:0] fft_tuser;
   logic [NB*AW-1:0] bin_sel;
   logic [2*DW-1:0] cordic_in_tdata;
   logic cordic_in_tvalid, cordic_in_tready;
   logic [PW-1:0] cordic_out_tdata;
   logic cordic_out_tvalid;
   logic [NB*PW-1:0] phase_cur, dphase;
   logic [NB-1:0] dphase_stale;
   logic dphase_valid;

   multi_bin_phase_tracker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PHASE_WIDTH(PW), .NUM_BINS(NB)) dut (
      .clock(clock), .reset(reset),
      .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid), .fft_tready(fft_tready),
      .fft_tlast(fft_tlast), .fft_tuser(fft_tuser), .bin_sel(bin_sel),
      .cordic_in_tdata(cordic_in_tdata), .cordic_in_tvalid(cordic_in_tvalid),
      .cordic_in_tready(cordic_in_tready), .cordic_out_tdata(cordic_out_tdata),
      .cordic_out_tvalid(cordic_out_tvalid), .phase_cur(phase_cur), .dphase(dphase),
      .dphase_stale(dphase_stale), .dphase_valid(dphase_valid)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [NB*PW-1:0] pc;
      logic [NB*PW-1:0] dp;
      logic [NB-1:0]    st;
   } exp_t;

   exp_t exp_q[$];
   logic [2*DW-1:0] req_q[$];
   logic [PW-1:0] script_q[$];
   int checks = 0, errors = 0, stall = 0;

   logic [2:0] pv;
   logic [PW-1:0] pd0, pd1, pd2;
   logic held_v;
   logic [2*DW-1:0] held;
   exp_t e;
   logic busy, bad, pend;

   function automatic logic [2*DW-1:0] beat_data(input int b);
      return {24'(b * 16 + 7), 24'(b * 3 + 1)};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_phase_cur"}, 64'(phase_cur), 64'(0));
      check({tag, "_dphase"}, 64'(dphase), 64'(0));
      check({tag, "_stale"}, 64'(dphase_stale), 64'(2'b11));
      check({tag, "_dvalid"}, 64'(dphase_valid), 64'(0));
      check({tag, "_cordic_req"}, 64'({cordic_in_tvalid, cordic_in_tdata}), 64'(0));
      check({tag, "_fft_tready"}, 64'(fft_tready), 64'(1));
   endtask

   task automatic send_frame(input logic [AW-1:0] b0, b1, input int last, input logic [PW-1:0] p0, p1,
                             input logic push, input logic [PW-1:0] c0, c1, d0, d1, input logic [NB-1:0] st);
      exp_t x;
      int n;
      bin_sel = {b1, b0};
      req_q.push_back(int'(b0) <= last ? beat_data(int'(b0)) : '0);
      req_q.push_back(int'(b1) <= last ? beat_data(int'(b1)) : '0);
      script_q.push_back(p0);
      script_q.push_back(p1);
      if (push) begin
         x.pc = {c1, c0};
         x.dp = {d1, d0};
         x.st = st;
         exp_q.push_back(x);
      end
      for (int b = 0; b <= last; b++) begin
         fft_tdata  = beat_data(b);
         fft_tuser  = AW'(b);
         fft_tlast  = b == last;
         fft_tvalid = 1'b1;
         n = 0;
         while (!fft_tready && n < 500) begin
            @(negedge clock);
            n++;
         end
         if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: beat %0d not accepted, required acceptance within 500 cycles", b);
         end
         @(negedge clock);
      end
      fft_tvalid = 1'b0;
      fft_tlast  = 1'b0;
   endtask

   // Scripted CORDIC: stalls on request, checks request content/stability, returns phases 3 cycles later.
   initial begin
      pv = '0; pd0 = '0; pd1 = '0; pd2 = '0; held_v = 1'b0; held = '0;
      cordic_in_tready = 1'b1; cordic_out_tvalid = 1'b0; cordic_out_tdata = '0;
      forever begin
         @(negedge clock);
         cordic_out_tvalid = pv[2];
         cordic_out_tdata  = pd2;
         pv  = {pv[1:0], 1'b0};
         pd2 = pd1; pd1 = pd0; pd0 = '0;
         if (held_v) check("req_stable", 64'({cordic_in_tvalid, cordic_in_tdata}), 64'({1'b1, held}));
         if (cordic_in_tvalid && stall > 0) begin
            cordic_in_tready = 1'b0;
            stall--;
         end else cordic_in_tready = 1'b1;
         held_v = cordic_in_tvalid && !cordic_in_tready;
         held   = cordic_in_tdata;
         if (cordic_in_tvalid && cordic_in_tready) begin
            if (req_q.size() == 0 || script_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cordic_req: got unexpected request %h, required none", cordic_in_tdata);
            end else begin
               check("cordic_req", 64'(cordic_in_tdata), 64'(req_q.pop_front()));
               pv[0] = 1'b1;
               pd0   = script_q.pop_front();
            end
         end
      end
   end

   // Monitor: scoreboard on dphase_valid plus fft_tready gating around each frame's processing.
   initial begin
      busy = 1'b0; bad = 1'b0; pend = 1'b0;
      forever begin
         @(negedge clock);
         #1;
         if (reset) begin
            busy = 1'b0; bad = 1'b0; pend = 1'b0;
         end else begin
            if (pend) begin
               check("tready_after_valid", 64'(fft_tready), 64'(1));
               pend = 1'b0;
            end
            if (dphase_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL dphase_valid: got unexpected pulse, required none");
               end else begin
                  e = exp_q.pop_front();
                  check("phase_cur", 64'(phase_cur), 64'(e.pc));
                  check("dphase", 64'(dphase), 64'(e.dp));
                  check("stale", 64'(dphase_stale), 64'(e.st));
               end
               check("tready_blocked", 64'({bad, fft_tready}), 64'(0));
               busy = 1'b0; bad = 1'b0; pend = 1'b1;
            end else if (busy && fft_tready) bad = 1'b1;
            if (fft_tvalid && fft_tready && fft_tlast) busy = 1'b1;
         end
      end
   end

   initial begin
      int n;
      fft_tvalid = 1'b0; fft_tlast = 1'b0; fft_tdata = '0; fft_tuser = '0; bin_sel = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check_reset("init");
      send_frame(3, 5, 15, 24'h100000, 24'h200000, 1, 24'h100000, 24'h200000, 24'h000000, 24'h000000, 2'b11);
      send_frame(3, 5, 15, 24'h180000, 24'h1F0000, 1, 24'h180000, 24'h1F0000, 24'h080000, 24'hFF0000, 2'b00);
      send_frame(3, 5, 15, 24'h7F0000, 24'h1F0000, 1, 24'h7F0000, 24'h1F0000, 24'h670000, 24'h000000, 2'b00);
      stall = 5;
      send_frame(3, 5, 15, 24'h810000, 24'h200000, 1, 24'h810000, 24'h200000, 24'h020000, 24'h010000, 2'b00);
      send_frame(3, 7, 15, 24'h830000, 24'h300000, 1, 24'h830000, 24'h300000, 24'h020000, 24'h000000, 2'b10);
      send_frame(3, 9, 5,  24'h840000, 24'h123456, 1, 24'h840000, 24'h300000, 24'h010000, 24'h000000, 2'b10);
      send_frame(3, 9, 15, 24'h850000, 24'h400000, 1, 24'h850000, 24'h400000, 24'h010000, 24'h000000, 2'b10);
      send_frame(3, 9, 15, 24'h860000, 24'h410000, 0, 24'h0, 24'h0, 24'h0, 24'h0, 2'b00);
      n = 0;
      while (!cordic_in_tvalid && n < 100) begin
         @(negedge clock);
         n++;
      end
      while (cordic_in_tvalid && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("reach_wait", 64'({n < 100, cordic_in_tvalid, fft_tready, dphase_valid}), 64'(4'b1000));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_reset("mid_wait_reset");
      send_frame(3, 9, 15, 24'h870000, 24'h420000, 1, 24'h870000, 24'h420000, 24'h000000, 24'h000000, 2'b11);
      n = 0;
      while (exp_q.size() > 0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      repeat (3) @(negedge clock);
      check("exp_drained", 64'(exp_q.size()), 64'(0));
      check("req_drained", 64'(req_q.size()), 64'(0));
      check("script_drained", 64'(script_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_bin_phase_tracker.md
Name: multi_bin_phase_tracker

Overview:
- Streaming successor to phase_detector. Tracks frame-to-frame phase advance of NUM_BINS selectable FFT bins at once, instead of one k_max bin.
- Captures the selected complex bins from the FFT AXI-stream and converts each to phase through an external CORDIC (AXI-stream request/response).
- Outputs current phase and wrapped delta phase per bin, plus per-slot stale flags. Sits between FFT output and the pitch-shift phase-vocoder math.

Parameters:
- DATA_WIDTH, 24, width of each re/im component.
- ADDR_WIDTH, 11, bin index width (frame length 2**ADDR_WIDTH).
- PHASE_WIDTH, 24, phase word width. Two's complement fraction of one turn; -2**(PHASE_WIDTH-1) = -pi.
- NUM_BINS, 4, number of tracked bin slots (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fft_tdata  in  2*DATA_WIDTH  {im,re}
- fft_tvalid  in  1  FFT beat valid
- fft_tready  out  1  beat accepted when tvalid&tready
- fft_tlast  in  1  last beat of frame
- fft_tuser  in  ADDR_WIDTH  bin index of beat
- bin_sel  in  NUM_BINS*ADDR_WIDTH  slot i bin = bin_sel[i*ADDR_WIDTH+:ADDR_WIDTH]
- cordic_in_tdata  out  2*DATA_WIDTH  {im,re} request
- cordic_in_tvalid  out  1  request valid
- cordic_in_tready  in  1  CORDIC ready
- cordic_out_tdata  in  PHASE_WIDTH  phase result, returned in request order
- cordic_out_tvalid  in  1  result valid
- phase_cur  out  NUM_BINS*PHASE_WIDTH  current phase per slot
- dphase  out  NUM_BINS*PHASE_WIDTH  wrapped delta phase per slot
- dphase_stale  out  NUM_BINS  1 = slot has no valid history; dphase forced 0
- dphase_valid  out  1  one-cycle pulse; all phase outputs updated

Behaviour:
- One clock, `clock`. Synchronous active-high `reset`.
- Reset values:
  - outputs: phase_cur=0, dphase=0, dphase_stale=all 1, dphase_valid=0, cordic_in_tvalid=0, cordic_in_tdata=0.
  - fft_tready=1 from the first cycle after reset.
  - internal: history invalid, frame_start=1, state CAPTURE.
- FSM:
  - CAPTURE:
    - fft_tready=1.
    - On the accepted beat with frame_start=1, latch bin_sel into bin_lat. That beat is compared against the new bin_lat.
    - Every accepted beat: each slot with fft_tuser==bin_lat[i] stores fft_tdata and sets seen[i]. Duplicate bins in several slots are all captured.
    - Accepted beat with tlast: capture it first, then go to SEND and set frame_start=1.
  - SEND:
    - fft_tready=0.
    - Present slot requests 0..NUM_BINS-1 in order. cordic_in_tdata/tvalid stay stable until tready.
    - Unseen slots still send {0,0}; their result is discarded.
    - After the last handshake, go to WAIT.
  - WAIT:
    - fft_tready=0.
    - Results are counted in both SEND and WAIT; result n belongs to slot n.
    - When NUM_BINS results are counted, go to UPDATE.
  - UPDATE (1 cycle), per slot:
    - seen & hist_valid & bin_lat==bin_prev: dphase=cur-prev mod 2**PHASE_WIDTH (natural two's complement wrap); stale=0.
    - Otherwise dphase=0 and stale=1.
    - If seen: prev<=cur, bin_prev<=bin_lat, hist_valid<=1, phase_cur<=cur.
    - If not seen: hist_valid<=0; phase_cur holds.
    - dphase_valid=1. Clear seen[]. Go to CAPTURE.
- Latency, tlast acceptance to dphase_valid: >= NUM_BINS + CORDIC latency + 1 cycles.
- cordic_out_tvalid in CAPTURE is ignored.
- Reset mid-frame or mid-WAIT: next cycle equals post-reset state. Results still in flight are ignored until the next SEND. The next frame reports all slots stale.
- Outputs hold between dphase_valid pulses.

Decomposition:
- Package phase_tracker_pkg:
  - state_t enum {CAPTURE,SEND,WAIT,UPDATE}.
  - Function phase_wrap_sub(a,b).
  - Localparam slot-counter width $clog2(NUM_BINS+1).
- No sub-module required. An optional bin_slot (capture register + compare + history) generated NUM_BINS times.

Test Plan:
Setup for all cases: DATA_WIDTH=24, PHASE_WIDTH=24, ADDR_WIDTH=4, NUM_BINS=2, 16-beat frames. Model CORDIC: 3-cycle latency, returns scripted phases.
1. Reset release; frame bins {3,5}, CORDIC returns 0x100000,0x200000 -> fft_tready=1 during frame. After tlast, one dphase_valid pulse: phase_cur={0x200000,0x100000}, dphase=0, stale=2'b11.
2. Next frame, same bins, results 0x180000,0x1F0000 -> dphase slot0=0x080000, slot1=0xFF0000 (-0x010000); stale=2'b00.
3. Wrap: slot0 prev 0x7F0000, cur 0x810000 -> dphase slot0=0x020000, stale bit 0 clear.
4. Hold cordic_in_tready=0 for 5 cycles in SEND -> cordic_in_tdata stable; fft_tready=0 until the cycle after dphase_valid; offered FFT beats are not consumed.
5. Slot1 bin changed 5->7 -> stale=2'b10, dphase slot1=0. Then a short frame (tlast at tuser 5) with slot1 bin 9 -> slot1 stale, phase_cur slot1 unchanged; next full frame with bin 9 -> slot1 still stale.
6. Reset asserted 1 cycle during WAIT -> next cycle outputs at reset values, fft_tready=1. Late CORDIC results are ignored. Next frame stale=2'b11.
